snake_mover: RTL and testbench
==============================

Name: snake_mover

Overview:
- Movement/collision engine for the greedy-snake game; sits directly downstream of the game state machine.
- On each move request it advances the snake one cell in the requested direction, detects wall and self collision, handles food consumption (growth plus score), then reports completion.
- Its score and dead outputs feed back to the state machine.
- Its body read port feeds the VGA renderer.

Parameters:
- GRID_W, 32, playfield width in cells (x = 0..GRID_W-1).
- GRID_H, 24, playfield height in cells (y = 0..GRID_H-1).
- MAX_LEN, 16, body segment capacity (power of 2).
- CW, 5, coordinate width in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous re-initialise (game restart).
- en  in  1  move request, level; a step starts on its rising edge.
- dir  in  2  requested direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- food_x  in  CW  food cell x.
- food_y  in  CW  food cell y.
- food_valid  in  1  food position is meaningful.
- done  out  1  one-cycle pulse when a step completes.
- dead  out  1  sticky collision flag.
- ate  out  1  one-cycle pulse, coincident with done, when food was eaten this step.
- score  out  8  food count.
- length  out  log2(MAX_LEN)+1  current segment count.
- head_x, head_y  out  CW  segment 0 coordinates.
- rd_idx  in  log2(MAX_LEN)  renderer segment select.
- rd_x, rd_y  out  CW  coordinates of segment rd_idx (combinational).
- rd_valid  out  1  rd_idx < length.

Behaviour:
- Reset (rst_n low, async) and clear (sync, highest priority, aborts any in-flight step) give:
  - state IDLE; length=3; cur_dir=right.
  - seg0=(GRID_W/2, GRID_H/2), seg1=(GRID_W/2-1, GRID_H/2), seg2=(GRID_W/2-2, GRID_H/2).
  - score=0; dead=0; done=0; ate=0; en_d=0.
- en_d registers en every cycle. A step starts only in IDLE, with en & ~en_d and dead=0. en is ignored otherwise; rising edges during a step are dropped, not queued.
- FSM states: IDLE -> CALC -> SCAN -> COMMIT -> DONE -> IDLE.
- CALC (1 cycle):
  - If dir is the opposite of cur_dir (up/down or left/right), keep cur_dir; else cur_dir <= dir.
  - Compute new head from the updated cur_dir.
  - Wall check: x-1 at x=0, y-1 at y=0, x+1 at GRID_W-1, or y+1 at GRID_H-1 sets dead=1 and goes straight to DONE. No wrap-around; the body is unchanged.
  - eat = food_valid and new head == (food_x, food_y).
- SCAN (exactly `length` cycles, index i = 0..length-1):
  - Compare seg[i] with the new head.
  - Index length-1 (the tail) is skipped when eat=0, because the tail vacates.
  - Any match sets hit.
- COMMIT (1 cycle):
  - If hit: dead=1, body unchanged.
  - Else: seg[k] <= seg[k-1] for k=length..1, seg0 <= new head.
  - If eat and length < MAX_LEN: length+1 (old tail retained).
  - If eat and length = MAX_LEN: shift without growth.
  - If eat: score+1, saturating at 255.
- DONE (1 cycle): done=1; ate=eat && !dead-this-step.
- Latency from the cycle en is first sampled high to done high:
  - Normal step: length+3 cycles.
  - Wall death: 2 cycles.
- dead stays 1 until clear or reset. score and length hold their values after death.
- Segments at index >= length hold stale values; rd_valid=0 for them.

Test Plan:
- Reset then en pulse with dir=11 -> done after 6 cycles; head=(17,12); length=3; score=0; dead=0; ate=0.
- Reset, dir=10 (reverse of right) -> treated as right; head=(17,12).
- Food at (17,12) with food_valid=1, one step right -> ate=1, score=1, length=4, segment 3=(14,12).
- Drive right repeatedly from x=16: steps 1-15 normal; step 16 at x=31 -> dead=1 with done 2 cycles after en; further en pulses produce no done.
- Grow to length 5, then path up, left, down -> head hits its own body -> dead=1, body unchanged. Separately, a move into the tail's vacating cell with no food -> dead=0.
- Assert clear in the middle of SCAN -> next cycle reset state and no done pulse. Hold en high continuously -> exactly one step per rising edge. score saturates at 255 with length capped at 16.

Source files
------------

// File: rtl/snake_mover.sv
// Movement/collision engine for the snake game: one move per en rising edge,
// with wall/self collision, food growth and a combinational body read port.
`timescale 1ns/1ps
module snake_mover #(
    parameter int unsigned GRID_W  = 32,
    parameter int unsigned GRID_H  = 24,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CW      = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       en,
    input  logic [1:0]                 dir,
    input  logic [CW-1:0]              food_x,
    input  logic [CW-1:0]              food_y,
    input  logic                       food_valid,
    output logic                       done,
    output logic                       dead,
    output logic                       ate,
    output logic [7:0]                 score,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic [CW-1:0]              head_x,
    output logic [CW-1:0]              head_y,
    input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
    output logic [CW-1:0]              rd_x,
    output logic [CW-1:0]              rd_y,
    output logic                       rd_valid
);
    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam int unsigned LW = IW + 1;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_SCAN,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [1:0]    cur_dir;
    logic [CW-1:0] seg_x [MAX_LEN];
    logic [CW-1:0] seg_y [MAX_LEN];
    logic [CW-1:0] nh_x;
    logic [CW-1:0] nh_y;
    logic [LW-1:0] scan_i;
    logic          eat;
    logic          hit;
    logic          en_d;

    logic [1:0]    eff_dir;
    logic [CW-1:0] calc_x;
    logic [CW-1:0] calc_y;
    logic          wall;
    logic          scan_last;
    logic          scan_hit;

    // Reversal is ignored: the pair differs only in bit 0 within an axis.
    always_comb begin
        eff_dir = ((dir[1] == cur_dir[1]) && (dir[0] != cur_dir[0])) ? cur_dir : dir;
        calc_x  = seg_x[0];
        calc_y  = seg_y[0];
        wall    = 1'b0;
        case (eff_dir)
            DIR_UP: begin
                if (seg_y[0] == '0) wall = 1'b1;
                else                calc_y = seg_y[0] - CW'(1);
            end
            DIR_DOWN: begin
                if (seg_y[0] == CW'(GRID_H - 1)) wall = 1'b1;
                else                             calc_y = seg_y[0] + CW'(1);
            end
            DIR_LEFT: begin
                if (seg_x[0] == '0) wall = 1'b1;
                else                calc_x = seg_x[0] - CW'(1);
            end
            default: begin
                if (seg_x[0] == CW'(GRID_W - 1)) wall = 1'b1;
                else                             calc_x = seg_x[0] + CW'(1);
            end
        endcase
        // The tail cell vacates on a non-growing move, so it cannot collide.
        scan_last = (scan_i == length - LW'(1));
        scan_hit  = (seg_x[scan_i[IW-1:0]] == nh_x) && (seg_y[scan_i[IW-1:0]] == nh_y)
                    && (eat || !scan_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur_dir <= DIR_RIGHT;
            length  <= LW'(3);
            score   <= 8'd0;
            dead    <= 1'b0;
            done    <= 1'b0;
            ate     <= 1'b0;
            en_d    <= 1'b0;
            nh_x    <= '0;
            nh_y    <= '0;
            scan_i  <= '0;
            eat     <= 1'b0;
            hit     <= 1'b0;
            for (int k = 0; k < int'(MAX_LEN); k++) begin
                seg_x[k] <= (k < 3) ? CW'(int'(GRID_W / 2) - k) : '0;
                seg_y[k] <= (k < 3) ? CW'(GRID_H / 2) : '0;
            end
        end else if (clear) begin
            state   <= S_IDLE;
            cur_dir <= DIR_RIGHT;
            length  <= LW'(3);
            score   <= 8'd0;
            dead    <= 1'b0;
            done    <= 1'b0;
            ate     <= 1'b0;
            en_d    <= 1'b0;
            nh_x    <= '0;
            nh_y    <= '0;
            scan_i  <= '0;
            eat     <= 1'b0;
            hit     <= 1'b0;
            for (int k = 0; k < int'(MAX_LEN); k++) begin
                seg_x[k] <= (k < 3) ? CW'(int'(GRID_W / 2) - k) : '0;
                seg_y[k] <= (k < 3) ? CW'(GRID_H / 2) : '0;
            end
        end else begin
            en_d <= en;
            done <= 1'b0;
            ate  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && !en_d && !dead) state <= S_CALC;
                end
                S_CALC: begin
                    cur_dir <= eff_dir;
                    nh_x    <= calc_x;
                    nh_y    <= calc_y;
                    eat     <= food_valid && (calc_x == food_x) && (calc_y == food_y);
                    hit     <= 1'b0;
                    scan_i  <= '0;
                    if (wall) begin
                        dead  <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_hit) hit <= 1'b1;
                    if (scan_last) state <= S_COMMIT;
                    else           scan_i <= scan_i + LW'(1);
                end
                S_COMMIT: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                    if (hit) begin
                        dead <= 1'b1;
                    end else begin
                        // Shifting the full array keeps the old tail at index length for growth.
                        for (int k = int'(MAX_LEN) - 1; k > 0; k--) begin
                            seg_x[k] <= seg_x[k-1];
                            seg_y[k] <= seg_y[k-1];
                        end
                        seg_x[0] <= nh_x;
                        seg_y[0] <= nh_y;
                        if (eat) begin
                            ate <= 1'b1;
                            if (length < LW'(MAX_LEN)) length <= length + LW'(1);
                            if (score != 8'hFF)        score  <= score + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign head_x   = seg_x[0];
    assign head_y   = seg_y[0];
    assign rd_x     = seg_x[rd_idx];
    assign rd_y     = seg_y[rd_idx];
    assign rd_valid = ({1'b0, rd_idx} < length);

endmodule

// File: tb/tb_snake_mover.sv
// Self-checking bench for snake_mover: directed scenarios plus randomized moves
// compared against a queue-based model of the snake body.
`timescale 1ns/1ps
module tb_snake_mover;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       en;
    logic [1:0] dir;
    logic [4:0] food_x;
    logic [4:0] food_y;
    logic       food_valid;
    logic       done;
    logic       dead;
    logic       ate;
    logic [7:0] score;
    logic [4:0] length;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [3:0] rd_idx;
    logic [4:0] rd_x;
    logic [4:0] rd_y;
    logic       rd_valid;

    int tests = 0;
    int fails = 0;

    // Reference model: body as a queue of cells, head at index 0.
    int bx[$];
    int by[$];
    int m_dir;
    int m_score;
    bit m_dead;

    always #5 clk = ~clk;

    snake_mover dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .dir(dir),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .done(done), .dead(dead), .ate(ate), .score(score), .length(length),
        .head_x(head_x), .head_y(head_y), .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dxo(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int dyo(input int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    function automatic int eff(input int d);
        return ((d ^ 1) == m_dir) ? m_dir : d;
    endfunction

    task automatic model_reset();
        bx = '{16, 15, 14};
        by = '{12, 12, 12};
        m_dir = 3;
        m_score = 0;
        m_dead = 0;
    endtask

    task automatic check_state();
        check("dead", 32'(dead), 32'(m_dead));
        check("score", 32'(score), 32'(m_score));
        check("length", 32'(length), 32'(bx.size()));
        check("head_x", 32'(head_x), 32'(bx[0]));
        check("head_y", 32'(head_y), 32'(by[0]));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_idx = 4'(i);
            #1;
            check("rd_valid", 32'(rd_valid), 32'(i < bx.size()));
            if (i < bx.size()) begin
                check("rd_x", 32'(rd_x), 32'(bx[i]));
                check("rd_y", 32'(rd_y), 32'(by[i]));
            end
        end
    endtask

    // mode 0: one-cycle en pulse; 1: en held high; 2: en jitters during the step
    task automatic do_step(input int d, input bit fv, input int fx, input int fy, input int mode);
        bit exp_done;
        bit exp_ate;
        int exp_lat;
        int nd, nx, ny, n;
        bit eat_m, hit_m;
        int lat;
        bit got;
        logic a;
        int q;
        exp_done = !m_dead;
        exp_ate = 0;
        exp_lat = 0;
        if (!m_dead) begin
            nd = eff(d);
            m_dir = nd;
            nx = bx[0] + dxo(nd);
            ny = by[0] + dyo(nd);
            if (nx < 0 || nx >= 32 || ny < 0 || ny >= 24) begin
                m_dead = 1;
                exp_lat = 2;
            end else begin
                eat_m = fv && (nx == fx) && (ny == fy);
                n = bx.size();
                exp_lat = n + 3;
                hit_m = 0;
                for (int i = 0; i < n; i++)
                    if (bx[i] == nx && by[i] == ny && (eat_m || i != n - 1)) hit_m = 1;
                if (hit_m) begin
                    m_dead = 1;
                end else begin
                    bx.push_front(nx);
                    by.push_front(ny);
                    if (!eat_m || n == 16) begin
                        void'(bx.pop_back());
                        void'(by.pop_back());
                    end
                    if (eat_m) begin
                        if (m_score < 255) m_score++;
                        exp_ate = 1;
                    end
                end
            end
        end

        @(negedge clk);
        dir = 2'(d);
        food_x = 5'(fx);
        food_y = 5'(fy);
        food_valid = fv;
        en = 1'b1;
        lat = 0;
        got = 0;
        a = 1'b0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1;
                a = ate;
            end
            if (mode == 0)      en = 1'b0;
            else if (mode == 2) en = got ? 1'b0 : 1'($urandom_range(0, 1));
        end
        if (exp_done) begin
            check("latency", got ? 32'(lat) : 32'hFFFF, 32'(exp_lat));
            check("ate", 32'(a), 32'(exp_ate));
        end else begin
            check("no_done", 32'(got), 32'd0);
        end
        if (mode == 1) begin
            q = 0;
            repeat (25) begin
                @(negedge clk);
                if (done) q++;
            end
            check("hold_extra", 32'(q), 32'd0);
        end
        en = 1'b0;
        if (got) begin
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd0);
        end
        check_state();
    endtask

    task automatic clear_dut();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        check("clr_done", 32'(done), 32'd0);
        check("clr_len", 32'(length), 32'd3);
    endtask

    int d;
    int nd;
    int q;
    int fx, fy;

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        en = 1'b0;
        dir = 2'b00;
        food_x = '0;
        food_y = '0;
        food_valid = 1'b0;
        rd_idx = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ate", 32'(ate), 32'd0);
        check_state();

        // Plain right step from reset, then a reversal request
        do_step(3, 0, 0, 0, 0);
        check("first_head_x", 32'(head_x), 32'd17);
        clear_dut();
        do_step(2, 0, 0, 0, 0);
        check("rev_head_x", 32'(head_x), 32'd17);

        // Eat on the first step
        clear_dut();
        do_step(3, 1, 17, 12, 0);
        check("eat_score", 32'(score), 32'd1);
        check("eat_len", 32'(length), 32'd4);

        // Run into the right wall, then further requests are ignored
        clear_dut();
        for (int i = 0; i < 16; i++) do_step(3, 0, 0, 0, 0);
        check("wall_dead", 32'(dead), 32'd1);
        do_step(0, 0, 0, 0, 0);

        // Self collision at length 5
        clear_dut();
        do_step(3, 1, 17, 12, 0);
        do_step(3, 1, 18, 12, 0);
        do_step(0, 0, 0, 0, 0);
        do_step(2, 0, 0, 0, 0);
        do_step(1, 0, 0, 0, 0);
        check("self_dead", 32'(dead), 32'd1);

        // Moving into the vacating tail is legal
        clear_dut();
        do_step(3, 1, 17, 12, 0);
        do_step(0, 0, 0, 0, 0);
        do_step(2, 0, 0, 0, 0);
        do_step(1, 0, 0, 0, 0);
        check("tail_alive", 32'(dead), 32'd0);

        // Clear in the middle of SCAN aborts the step
        clear_dut();
        @(negedge clk);
        dir = 2'b11;
        food_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        q = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) q++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(q), 32'd0);
        check_state();

        // en held high: exactly one step
        do_step(3, 0, 0, 0, 1);

        // Saturate score while looping a rectangle, feeding the next cell each step
        clear_dut();
        for (int s = 0; s < 262; s++) begin
            if (s < 5)       d = 3;
            else if (s < 10) d = 1;
            else begin
                case (((s - 10) % 36) / 9)
                    0: d = 2;
                    1: d = 0;
                    2: d = 3;
                    default: d = 1;
                endcase
            end
            nd = eff(d);
            do_step(d, 1, bx[0] + dxo(nd), by[0] + dyo(nd), 0);
        end
        check("sat_score", 32'(score), 32'd255);
        check("sat_len", 32'(length), 32'd16);
        check("sat_alive", 32'(dead), 32'd0);

        // Randomized moves with jittering en; restart on death
        clear_dut();
        for (int s = 0; s < 150; s++) begin
            d = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                nd = eff(d);
                fx = bx[0] + dxo(nd);
                fy = by[0] + dyo(nd);
            end else begin
                fx = int'($urandom_range(0, 31));
                fy = int'($urandom_range(0, 23));
            end
            do_step(d, 1'($urandom_range(0, 1)), fx, fy, 2);
            if (m_dead) begin
                do_step(int'($urandom_range(0, 3)), 0, 0, 0, 0);
                clear_dut();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
